mds_mul_serial: RTL

- Downstream consumer of the q0/q1 byte-permutation stage inside the Twofish g/h function.
- Takes the 32-bit word formed by four permuted bytes (y0 = least-significant byte) and multiplies it by the Twofish MDS matrix over GF(2^8), primitive polynomial x^8+x^6+x^5+x^3+1 (0x169).
- Processes one input byte (one matrix column) per cycle, accumulating by XOR, to keep multiplier area small.
- Valid/ready handshake on both sides.

---
 rtl/mds_mul_serial.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mds_mul_serial.sv
// mds_mul_serial: Twofish MDS matrix multiply over GF(2^8), one matrix column per cycle.
//
// The 32-bit word y = {y3,y2,y1,y0} is latched on the input handshake. Over the next
// NBYTES cycles, column j of the MDS matrix is scaled by y_j and XORed into a 32-bit
// accumulator. The finished word z = {z3,z2,z1,z0} is then presented until it is accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word in_y is valid
//   in_ready   block can accept a word (IDLE only)
//   in_y       input word {y3,y2,y1,y0}, y0 = bits 7:0
//   out_valid  result out_z is valid (DONE only)
//   out_ready  downstream accepts out_z
//   out_z      result word {z3,z2,z1,z0}, z0 = bits 7:0; changes only on completion
//   busy       high in any state other than IDLE
module mds_mul_serial #(
  parameter logic [8:0]  POLY   = 9'h169,
  parameter int unsigned NBYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic        busy
);

  localparam int unsigned CntW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NBYTES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     y_q, y_d;
  logic [31:0]     acc_q, acc_d;
  logic [31:0]     z_q, z_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Multiply by x modulo POLY. POLY carries the x^8 term, so XORing it clears bit 8.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    logic [8:0] sh;
    sh = {a, 1'b0};
    if (sh[8]) begin
      sh = sh ^ POLY;
    end
    return sh[7:0];
  endfunction

  // Multiply by a constant: XOR together the xtime powers of a selected by c's set bits.
  // With c constant, synthesis reduces this to a small XOR network.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] pw;
    logic [7:0] res;
    pw  = a;
    res = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) begin
        res = res ^ pw;
      end
      pw = xtime(pw);
    end
    return res;
  endfunction

  // Byte selected by the column counter.
  logic [7:0] y_sel;

  always_comb begin
    y_sel = y_q[7:0];
    unique case (cnt_q)
      2'd0:    y_sel = y_q[7:0];
      2'd1:    y_sel = y_q[15:8];
      2'd2:    y_sel = y_q[23:16];
      2'd3:    y_sel = y_q[31:24];
      default: y_sel = y_q[7:0];
    endcase
  end

  // Only three distinct coefficients appear in the matrix: 01, 5B, EF.
  logic [7:0] m01, m5b, mef;

  assign m01 = y_sel;
  assign m5b = gf_mul_const(y_sel, 8'h5B);
  assign mef = gf_mul_const(y_sel, 8'hEF);

  // Scaled column for the current byte, packed as {row3,row2,row1,row0}.
  // Columns (row0,row1,row2,row3):
  //   j0 = (01,5B,EF,EF)  j1 = (EF,EF,5B,01)  j2 = (5B,EF,01,EF)  j3 = (5B,01,EF,5B)
  logic [31:0] col_term;

  always_comb begin
    col_term = 32'h0;
    unique case (cnt_q)
      2'd0:    col_term = {mef, mef, m5b, m01};
      2'd1:    col_term = {m01, m5b, mef, mef};
      2'd2:    col_term = {mef, m01, mef, m5b};
      2'd3:    col_term = {m5b, mef, m01, m5b};
      default: col_term = 32'h0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    z_d     = z_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          y_d     = in_y;
          acc_d   = 32'h0;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end

      StBusy: begin
        acc_d = acc_q ^ col_term;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          // Publish the final sum directly; out_z never shows a partial accumulation.
          z_d     = acc_q ^ col_term;
          state_d = StDone;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      y_q     <= 32'h0;
      acc_q   <= 32'h0;
      z_q     <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_z     = z_q;

endmodule
